// File: rtl/scr1_dmi_arb_pkg.sv
// Shared DMI width constants and arbiter types.
package scr1_dmi_arb_pkg;

    localparam int unsigned SCR1_DBG_DMI_ADDR_WIDTH = 7;
    localparam int unsigned SCR1_DBG_DMI_DATA_WIDTH = 32;

    typedef logic [1:0] scr1_dmi_arb_state_e;

    localparam scr1_dmi_arb_state_e SCR1_DMI_ARB_IDLE   = 2'd0;
    localparam scr1_dmi_arb_state_e SCR1_DMI_ARB_ACCESS = 2'd1;
    localparam scr1_dmi_arb_state_e SCR1_DMI_ARB_RESP   = 2'd2;

    typedef struct packed {
        logic                               wr;
        logic [SCR1_DBG_DMI_ADDR_WIDTH-1:0] addr;
        logic [SCR1_DBG_DMI_DATA_WIDTH-1:0] wdata;
    } scr1_dmi_arb_req_s;

endpackage

// File: rtl/scr1_dmi_arb_port.sv
// One requester port: 1-entry capture buffer, pending flag and response registers.
module scr1_dmi_arb_port
    import scr1_dmi_arb_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               req,
    input  logic                               wr,
    input  logic [SCR1_DBG_DMI_ADDR_WIDTH-1:0] addr,
    input  logic [SCR1_DBG_DMI_DATA_WIDTH-1:0] wdata,
    input  logic                               done,
    input  logic                               done_err,
    input  logic [SCR1_DBG_DMI_DATA_WIDTH-1:0] done_rdata,
    output logic                               busy,
    output logic                               resp,
    output logic                               err,
    output logic [SCR1_DBG_DMI_DATA_WIDTH-1:0] rdata,
    output logic                               buf_wr,
    output logic [SCR1_DBG_DMI_ADDR_WIDTH-1:0] buf_addr,
    output logic [SCR1_DBG_DMI_DATA_WIDTH-1:0] buf_wdata
);

    scr1_dmi_arb_req_s buffer;
    logic              pending;

    // pending stays set until the access completes, so it also covers ownership
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            buffer  <= '0;
            resp    <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
        end else begin
            resp <= done;
            if (req && !pending) begin
                pending <= 1'b1;
                buffer  <= '{wr: wr, addr: addr, wdata: wdata};
            end else if (done) begin
                pending <= 1'b0;
            end
            if (done) begin
                err   <= done_err;
                rdata <= done_rdata;
            end
        end
    end

    assign busy      = pending;
    assign buf_wr    = buffer.wr;
    assign buf_addr  = buffer.addr;
    assign buf_wdata = buffer.wdata;

endmodule

// File: rtl/scr1_dmi_arb.sv
// Round-robin DMI arbiter between TAP (T) and system (S) requesters with DM watchdog.
module scr1_dmi_arb
    import scr1_dmi_arb_pkg::*;
#(
    parameter int unsigned SCR1_DMI_ARB_TIMEOUT  = 64,
    parameter int unsigned SCR1_DMI_ARB_TO_WIDTH = 7
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               tap2arb_req_i,
    input  logic                               tap2arb_wr_i,
    input  logic [SCR1_DBG_DMI_ADDR_WIDTH-1:0] tap2arb_addr_i,
    input  logic [SCR1_DBG_DMI_DATA_WIDTH-1:0] tap2arb_wdata_i,
    output logic                               arb2tap_busy_o,
    output logic                               arb2tap_resp_o,
    output logic                               arb2tap_err_o,
    output logic [SCR1_DBG_DMI_DATA_WIDTH-1:0] arb2tap_rdata_o,
    input  logic                               sys2arb_req_i,
    input  logic                               sys2arb_wr_i,
    input  logic [SCR1_DBG_DMI_ADDR_WIDTH-1:0] sys2arb_addr_i,
    input  logic [SCR1_DBG_DMI_DATA_WIDTH-1:0] sys2arb_wdata_i,
    output logic                               arb2sys_busy_o,
    output logic                               arb2sys_resp_o,
    output logic                               arb2sys_err_o,
    output logic [SCR1_DBG_DMI_DATA_WIDTH-1:0] arb2sys_rdata_o,
    output logic                               arb2dm_req_o,
    output logic                               arb2dm_wr_o,
    output logic [SCR1_DBG_DMI_ADDR_WIDTH-1:0] arb2dm_addr_o,
    output logic [SCR1_DBG_DMI_DATA_WIDTH-1:0] arb2dm_wdata_o,
    input  logic                               dm2arb_resp_i,
    input  logic [SCR1_DBG_DMI_DATA_WIDTH-1:0] dm2arb_rdata_i
);

    localparam logic [SCR1_DMI_ARB_TO_WIDTH-1:0] TO_LAST = SCR1_DMI_ARB_TO_WIDTH'(
        (SCR1_DMI_ARB_TIMEOUT == 0) ? 0 : SCR1_DMI_ARB_TIMEOUT - 1);

    scr1_dmi_arb_state_e              state, state_next;
    logic                             grant, grant_next;           // 0 = T, 1 = S
    logic                             last_grant, last_grant_next;
    logic [SCR1_DMI_ARB_TO_WIDTH-1:0] wdog, wdog_next;

    logic                               t_wr, s_wr, sel_wr;
    logic [SCR1_DBG_DMI_ADDR_WIDTH-1:0] t_addr, s_addr, sel_addr;
    logic [SCR1_DBG_DMI_DATA_WIDTH-1:0] t_wdata, s_wdata, sel_wdata;
    logic                               access, timeout_hit, done, done_err;
    logic [SCR1_DBG_DMI_DATA_WIDTH-1:0] done_rdata;

    assign access      = (state == SCR1_DMI_ARB_ACCESS);
    assign timeout_hit = (SCR1_DMI_ARB_TIMEOUT != 0) && (wdog == TO_LAST);
    assign done        = access && (dm2arb_resp_i || timeout_hit);
    // A DM response always wins over a coincident timeout
    assign done_err    = !dm2arb_resp_i;
    assign done_rdata  = (dm2arb_resp_i && !sel_wr) ? dm2arb_rdata_i : '0;

    assign sel_wr    = grant ? s_wr    : t_wr;
    assign sel_addr  = grant ? s_addr  : t_addr;
    assign sel_wdata = grant ? s_wdata : t_wdata;

    assign arb2dm_req_o   = access;
    assign arb2dm_wr_o    = access & sel_wr;
    assign arb2dm_addr_o  = access ? sel_addr  : '0;
    assign arb2dm_wdata_o = access ? sel_wdata : '0;

    scr1_dmi_arb_port u_port_t (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (tap2arb_req_i),
        .wr         (tap2arb_wr_i),
        .addr       (tap2arb_addr_i),
        .wdata      (tap2arb_wdata_i),
        .done       (done && !grant),
        .done_err   (done_err),
        .done_rdata (done_rdata),
        .busy       (arb2tap_busy_o),
        .resp       (arb2tap_resp_o),
        .err        (arb2tap_err_o),
        .rdata      (arb2tap_rdata_o),
        .buf_wr     (t_wr),
        .buf_addr   (t_addr),
        .buf_wdata  (t_wdata)
    );

    scr1_dmi_arb_port u_port_s (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (sys2arb_req_i),
        .wr         (sys2arb_wr_i),
        .addr       (sys2arb_addr_i),
        .wdata      (sys2arb_wdata_i),
        .done       (done && grant),
        .done_err   (done_err),
        .done_rdata (done_rdata),
        .busy       (arb2sys_busy_o),
        .resp       (arb2sys_resp_o),
        .err        (arb2sys_err_o),
        .rdata      (arb2sys_rdata_o),
        .buf_wr     (s_wr),
        .buf_addr   (s_addr),
        .buf_wdata  (s_wdata)
    );

    always_comb begin
        state_next      = state;
        grant_next      = grant;
        last_grant_next = last_grant;
        wdog_next       = wdog;
        case (state)
            SCR1_DMI_ARB_IDLE: begin
                wdog_next = '0;
                if (arb2tap_busy_o || arb2sys_busy_o) begin
                    state_next = SCR1_DMI_ARB_ACCESS;
                    // Pointer moves only on ties so alternation is per contested round
                    if (arb2tap_busy_o && arb2sys_busy_o) begin
                        grant_next      = ~last_grant;
                        last_grant_next = ~last_grant;
                    end else begin
                        grant_next = arb2sys_busy_o;
                    end
                end
            end
            SCR1_DMI_ARB_ACCESS: begin
                if (done) begin
                    state_next = SCR1_DMI_ARB_RESP;
                    wdog_next  = '0;
                end else if (SCR1_DMI_ARB_TIMEOUT != 0) begin
                    wdog_next = wdog + 1'b1;
                end
            end
            SCR1_DMI_ARB_RESP: begin
                state_next = SCR1_DMI_ARB_IDLE;
                wdog_next  = '0;
            end
            default: begin
                state_next = SCR1_DMI_ARB_IDLE;
                wdog_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SCR1_DMI_ARB_IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            wdog       <= '0;
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            last_grant <= last_grant_next;
            wdog       <= wdog_next;
        end
    end

endmodule

// File: tb/tb_scr1_dmi_arb.sv
// Directed bench for scr1_dmi_arb with immediate-assertion checks.
module tb_scr1_dmi_arb;
    import scr1_dmi_arb_pkg::*;

    logic                               clk = 1'b0;
    logic                               rst_n;
    logic                               tap2arb_req_i, tap2arb_wr_i;
    logic [SCR1_DBG_DMI_ADDR_WIDTH-1:0] tap2arb_addr_i;
    logic [SCR1_DBG_DMI_DATA_WIDTH-1:0] tap2arb_wdata_i;
    logic                               arb2tap_busy_o, arb2tap_resp_o, arb2tap_err_o;
    logic [SCR1_DBG_DMI_DATA_WIDTH-1:0] arb2tap_rdata_o;
    logic                               sys2arb_req_i, sys2arb_wr_i;
    logic [SCR1_DBG_DMI_ADDR_WIDTH-1:0] sys2arb_addr_i;
    logic [SCR1_DBG_DMI_DATA_WIDTH-1:0] sys2arb_wdata_i;
    logic                               arb2sys_busy_o, arb2sys_resp_o, arb2sys_err_o;
    logic [SCR1_DBG_DMI_DATA_WIDTH-1:0] arb2sys_rdata_o;
    logic                               arb2dm_req_o, arb2dm_wr_o;
    logic [SCR1_DBG_DMI_ADDR_WIDTH-1:0] arb2dm_addr_o;
    logic [SCR1_DBG_DMI_DATA_WIDTH-1:0] arb2dm_wdata_o;
    logic                               dm2arb_resp_i;
    logic [SCR1_DBG_DMI_DATA_WIDTH-1:0] dm2arb_rdata_i;

    int n_checks = 0;
    int n_fails  = 0;
    int tap_viol = 0;
    int cnt;

    always #5 clk = ~clk;

    scr1_dmi_arb dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .tap2arb_req_i   (tap2arb_req_i),
        .tap2arb_wr_i    (tap2arb_wr_i),
        .tap2arb_addr_i  (tap2arb_addr_i),
        .tap2arb_wdata_i (tap2arb_wdata_i),
        .arb2tap_busy_o  (arb2tap_busy_o),
        .arb2tap_resp_o  (arb2tap_resp_o),
        .arb2tap_err_o   (arb2tap_err_o),
        .arb2tap_rdata_o (arb2tap_rdata_o),
        .sys2arb_req_i   (sys2arb_req_i),
        .sys2arb_wr_i    (sys2arb_wr_i),
        .sys2arb_addr_i  (sys2arb_addr_i),
        .sys2arb_wdata_i (sys2arb_wdata_i),
        .arb2sys_busy_o  (arb2sys_busy_o),
        .arb2sys_resp_o  (arb2sys_resp_o),
        .arb2sys_err_o   (arb2sys_err_o),
        .arb2sys_rdata_o (arb2sys_rdata_o),
        .arb2dm_req_o    (arb2dm_req_o),
        .arb2dm_wr_o     (arb2dm_wr_o),
        .arb2dm_addr_o   (arb2dm_addr_o),
        .arb2dm_wdata_o  (arb2dm_wdata_o),
        .dm2arb_resp_i   (dm2arb_resp_i),
        .dm2arb_rdata_i  (dm2arb_rdata_i)
    );

    // Counts T requests issued while the port is busy (protocol misuse)
    always @(posedge clk) begin
        if (rst_n && tap2arb_req_i && arb2tap_busy_o) tap_viol++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed hang expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst_n = 1'b0;
        tap2arb_req_i = 0; tap2arb_wr_i = 0; tap2arb_addr_i = '0; tap2arb_wdata_i = '0;
        sys2arb_req_i = 0; sys2arb_wr_i = 0; sys2arb_addr_i = '0; sys2arb_wdata_i = '0;
        dm2arb_resp_i = 0; dm2arb_rdata_i = '0;
        #3;
        check("rst_dm_req", arb2dm_req_o, 0);
        check("rst_tap_busy", arb2tap_busy_o, 0);
        check("rst_sys_busy", arb2sys_busy_o, 0);
        check("rst_tap_resp", arb2tap_resp_o, 0);
        check("rst_sys_rdata", arb2sys_rdata_o, 0);
        #4 rst_n = 1'b1;
        step();

        // T read, DM responds in the same cycle
        tap2arb_req_i = 1; tap2arb_wr_i = 0; tap2arb_addr_i = 7'h11;
        step();
        tap2arb_req_i = 0;
        check("t1_busy", arb2tap_busy_o, 1);
        check("t1_dm_req_n1", arb2dm_req_o, 0);
        step();
        check("t1_dm_req_n2", arb2dm_req_o, 1);
        check("t1_dm_wr", arb2dm_wr_o, 0);
        check("t1_dm_addr", arb2dm_addr_o, 32'h11);
        dm2arb_resp_i = 1; dm2arb_rdata_i = 32'hDEADBEEF;
        step();
        dm2arb_resp_i = 0; dm2arb_rdata_i = '0;
        check("t1_resp", arb2tap_resp_o, 1);
        check("t1_rdata", arb2tap_rdata_o, 32'hDEADBEEF);
        check("t1_err", arb2tap_err_o, 0);
        check("t1_dm_req_drop", arb2dm_req_o, 0);
        check("t1_busy_clr", arb2tap_busy_o, 0);
        step();
        check("t1_resp_pulse", arb2tap_resp_o, 0);
        check("t1_rdata_hold", arb2tap_rdata_o, 32'hDEADBEEF);
        // Stray DM response in IDLE
        dm2arb_resp_i = 1; dm2arb_rdata_i = 32'h12345678;
        step();
        dm2arb_resp_i = 0; dm2arb_rdata_i = '0;
        check("stray_tap_resp", arb2tap_resp_o, 0);
        check("stray_sys_resp", arb2sys_resp_o, 0);
        check("stray_dm_req", arb2dm_req_o, 0);

        // S write, DM responds 3 cycles late
        sys2arb_req_i = 1; sys2arb_wr_i = 1; sys2arb_addr_i = 7'h04;
        sys2arb_wdata_i = 32'h80000001;
        step();
        sys2arb_req_i = 0;
        step();
        for (int i = 0; i < 4; i++) begin
            check("t2_dm_req", arb2dm_req_o, 1);
            check("t2_dm_wr", arb2dm_wr_o, 1);
            check("t2_dm_wdata", arb2dm_wdata_o, 32'h80000001);
            if (i == 3) dm2arb_resp_i = 1;
            step();
        end
        dm2arb_resp_i = 0;
        check("t2_dm_req_drop", arb2dm_req_o, 0);
        check("t2_sys_resp", arb2sys_resp_o, 1);
        check("t2_sys_err", arb2sys_err_o, 0);
        check("t2_sys_rdata", arb2sys_rdata_o, 0);
        check("t2_tap_resp", arb2tap_resp_o, 0);
        check("t2_tap_busy", arb2tap_busy_o, 0);
        step();

        // Simultaneous requests: T then S, then S then T
        tap2arb_req_i = 1; tap2arb_wr_i = 0; tap2arb_addr_i = 7'h21;
        sys2arb_req_i = 1; sys2arb_wr_i = 0; sys2arb_addr_i = 7'h22;
        step();
        tap2arb_req_i = 0; sys2arb_req_i = 0;
        check("t3_tap_busy", arb2tap_busy_o, 1);
        check("t3_sys_busy", arb2sys_busy_o, 1);
        step();
        check("t3a_first_addr", arb2dm_addr_o, 32'h21);
        dm2arb_resp_i = 1; dm2arb_rdata_i = 32'h11111111;
        step();
        dm2arb_resp_i = 0;
        check("t3a_tap_resp", arb2tap_resp_o, 1);
        check("t3a_tap_rdata", arb2tap_rdata_o, 32'h11111111);
        check("t3a_tap_busy", arb2tap_busy_o, 0);
        check("t3a_sys_busy", arb2sys_busy_o, 1);
        check("t3a_sys_resp", arb2sys_resp_o, 0);
        step();
        check("t3a_idle", arb2dm_req_o, 0);
        step();
        check("t3a_second_req", arb2dm_req_o, 1);
        check("t3a_second_addr", arb2dm_addr_o, 32'h22);
        dm2arb_resp_i = 1; dm2arb_rdata_i = 32'h22222222;
        step();
        dm2arb_resp_i = 0;
        check("t3a_sys_resp", arb2sys_resp_o, 1);
        check("t3a_sys_rdata", arb2sys_rdata_o, 32'h22222222);
        check("t3a_sys_busy_clr", arb2sys_busy_o, 0);
        step();
        tap2arb_req_i = 1; sys2arb_req_i = 1;
        step();
        tap2arb_req_i = 0; sys2arb_req_i = 0;
        step();
        check("t3b_first_addr", arb2dm_addr_o, 32'h22);
        dm2arb_resp_i = 1; dm2arb_rdata_i = 32'h33333333;
        step();
        dm2arb_resp_i = 0;
        check("t3b_sys_resp", arb2sys_resp_o, 1);
        check("t3b_sys_rdata", arb2sys_rdata_o, 32'h33333333);
        check("t3b_tap_busy", arb2tap_busy_o, 1);
        step();
        step();
        check("t3b_second_addr", arb2dm_addr_o, 32'h21);
        dm2arb_resp_i = 1; dm2arb_rdata_i = 32'h44444444;
        step();
        dm2arb_resp_i = 0;
        check("t3b_tap_resp", arb2tap_resp_o, 1);
        check("t3b_tap_rdata", arb2tap_rdata_o, 32'h44444444);
        step();

        // DM never answers: watchdog terminates after 64 cycles, queued S follows
        tap2arb_req_i = 1; tap2arb_wr_i = 0; tap2arb_addr_i = 7'h30;
        sys2arb_wr_i = 0; sys2arb_addr_i = 7'h31;
        step();
        tap2arb_req_i = 0;
        step();
        cnt = 0;
        while (arb2dm_req_o === 1'b1 && cnt < 100) begin
            sys2arb_req_i = (cnt == 3);
            cnt++;
            step();
        end
        sys2arb_req_i = 0;
        check("t4_req_cycles", cnt, 64);
        check("t4_tap_resp", arb2tap_resp_o, 1);
        check("t4_tap_err", arb2tap_err_o, 1);
        check("t4_tap_rdata", arb2tap_rdata_o, 0);
        check("t4_sys_queued", arb2sys_busy_o, 1);
        step();
        step();
        check("t4_next_req", arb2dm_req_o, 1);
        check("t4_next_addr", arb2dm_addr_o, 32'h31);
        dm2arb_resp_i = 1; dm2arb_rdata_i = 32'h55555555;
        step();
        dm2arb_resp_i = 0;
        check("t4_sys_resp", arb2sys_resp_o, 1);
        check("t4_sys_err", arb2sys_err_o, 0);
        check("t4_sys_rdata", arb2sys_rdata_o, 32'h55555555);
        step();

        // New T request in T's RESP cycle; T request while busy is dropped
        tap2arb_req_i = 1; tap2arb_addr_i = 7'h12;
        step();
        tap2arb_req_i = 0;
        step();
        dm2arb_resp_i = 1; dm2arb_rdata_i = 32'hA5A5A5A5;
        step();
        dm2arb_resp_i = 0;
        check("t5_resp", arb2tap_resp_o, 1);
        check("t5_err_clr", arb2tap_err_o, 0);
        check("t5_busy_in_resp", arb2tap_busy_o, 0);
        tap2arb_req_i = 1; tap2arb_addr_i = 7'h13;
        step();
        tap2arb_req_i = 0;
        check("t5_recaptured", arb2tap_busy_o, 1);
        check("t5_idle", arb2dm_req_o, 0);
        step();
        check("t5_req_again", arb2dm_req_o, 1);
        check("t5_addr_again", arb2dm_addr_o, 32'h13);
        tap2arb_req_i = 1; tap2arb_addr_i = 7'h7F;
        step();
        tap2arb_req_i = 0;
        check("t5_addr_kept", arb2dm_addr_o, 32'h13);
        dm2arb_resp_i = 1; dm2arb_rdata_i = 32'h0BADF00D;
        step();
        dm2arb_resp_i = 0;
        check("t5_resp2", arb2tap_resp_o, 1);
        check("t5_rdata2", arb2tap_rdata_o, 32'h0BADF00D);
        step();
        check("t5_dropped_busy", arb2tap_busy_o, 0);
        step();
        check("t5_dropped_req", arb2dm_req_o, 0);
        check("t5_violation_seen", tap_viol, 1);

        // Reset during ACCESS
        tap2arb_req_i = 1; tap2arb_addr_i = 7'h40;
        sys2arb_req_i = 1; sys2arb_addr_i = 7'h41;
        step();
        tap2arb_req_i = 0; sys2arb_req_i = 0;
        step();
        check("t6_pre_addr", arb2dm_addr_o, 32'h40);
        #2 rst_n = 1'b0;
        #1;
        check("t6_dm_req", arb2dm_req_o, 0);
        check("t6_tap_busy", arb2tap_busy_o, 0);
        check("t6_sys_busy", arb2sys_busy_o, 0);
        check("t6_tap_resp", arb2tap_resp_o, 0);
        #2 rst_n = 1'b1;
        step();
        check("t6_lost_t", arb2tap_busy_o, 0);
        check("t6_lost_s", arb2sys_busy_o, 0);
        tap2arb_req_i = 1; tap2arb_addr_i = 7'h50;
        sys2arb_req_i = 1; sys2arb_addr_i = 7'h51;
        step();
        tap2arb_req_i = 0; sys2arb_req_i = 0;
        step();
        check("t6_tie_grants_t", arb2dm_addr_o, 32'h50);
        dm2arb_resp_i = 1; dm2arb_rdata_i = 32'h66666666;
        step();
        dm2arb_resp_i = 0;
        check("t6_tap_resp_after", arb2tap_resp_o, 1);
        check("t6_tap_rdata_after", arb2tap_rdata_o, 32'h66666666);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
